// File: rtl/simplerisc_pkg.sv
// simplerisc_pkg: SimpleRisc opcode encoding, immediate-modifier codes and
// decode helpers shared by the operand-fetch stage.
package simplerisc_pkg;

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,
    OP_SUB  = 5'd1,
    OP_MUL  = 5'd2,
    OP_DIV  = 5'd3,
    OP_MOD  = 5'd4,
    OP_CMP  = 5'd5,
    OP_AND  = 5'd6,
    OP_OR   = 5'd7,
    OP_NOT  = 5'd8,
    OP_MOV  = 5'd9,
    OP_LSL  = 5'd10,
    OP_LSR  = 5'd11,
    OP_ASR  = 5'd12,
    OP_NOP  = 5'd13,
    OP_LD   = 5'd14,
    OP_ST   = 5'd15,
    OP_BEQ  = 5'd16,
    OP_BGT  = 5'd17,
    OP_B    = 5'd18,
    OP_CALL = 5'd19,
    OP_RET  = 5'd20
  } opcode_e;

  localparam logic [1:0] IMM_SEXT = 2'b00;
  localparam logic [1:0] IMM_ZEXT = 2'b01;
  localparam logic [1:0] IMM_HIGH = 2'b10;

  // call also writes (RA_REG) but is handled separately since its target is fixed.
  function automatic logic writes_rd(input logic [4:0] op);
    return (op <= OP_MOD) || ((op >= OP_AND) && (op <= OP_ASR)) || (op == OP_LD);
  endfunction

  function automatic logic uses_rs1(input logic [4:0] op);
    return !(op inside {OP_NOT, OP_MOV, OP_NOP, OP_B, OP_BEQ, OP_BGT, OP_CALL});
  endfunction

endpackage

// File: rtl/of_scoreboard.sv
// of_scoreboard: per-register in-flight write counters with increment on
// issue, decrement on writeback, rollback on flush, and hazard queries.
module of_scoreboard #(
  parameter int unsigned NREG     = 16,
  parameter int unsigned SB_CNT_W = 2,
  parameter int unsigned REG_AW   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_inc,
  input  logic [REG_AW-1:0] i_inc_reg,
  input  logic              i_dec,
  input  logic [REG_AW-1:0] i_dec_reg,
  input  logic              i_rb,
  input  logic [REG_AW-1:0] i_rb_reg,
  input  logic [REG_AW-1:0] i_q1,
  input  logic [REG_AW-1:0] i_q2,
  input  logic [REG_AW-1:0] i_qd,
  output logic              o_busy1,
  output logic              o_busy2,
  output logic              o_dsat
);

  logic [SB_CNT_W-1:0] r_cnt [NREG];
  logic [SB_CNT_W-1:0] w_nxt [NREG];

  // Inc and rollback never coincide (flush blocks issue); a decrement that
  // would underflow after them is dropped, so inc+dec on one reg nets to zero.
  always_comb begin
    for (int unsigned i = 0; i < NREG; i++) begin
      w_nxt[i] = r_cnt[i];
      if (i_inc && (i_inc_reg == REG_AW'(i)) && (w_nxt[i] != '1))
        w_nxt[i] = w_nxt[i] + SB_CNT_W'(1);
      if (i_rb && (i_rb_reg == REG_AW'(i)) && (w_nxt[i] != '0))
        w_nxt[i] = w_nxt[i] - SB_CNT_W'(1);
      if (i_dec && (i_dec_reg == REG_AW'(i)) && (w_nxt[i] != '0))
        w_nxt[i] = w_nxt[i] - SB_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) r_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NREG; i++) r_cnt[i] <= w_nxt[i];
    end
  end

  assign o_busy1 = (r_cnt[i_q1] != '0);
  assign o_busy2 = (r_cnt[i_q2] != '0);
  assign o_dsat  = (r_cnt[i_qd] == '1);

endmodule

// File: rtl/of_stage_pipe.sv
// of_stage_pipe: SimpleRisc operand-fetch stage with OF/EX latch and scoreboard.
// Define OF_WB_BYPASS_EN to forward same-cycle writeback data into operand reads.
module of_stage_pipe
  import simplerisc_pkg::*;
#(
  parameter  int unsigned XLEN     = 32,
  parameter  int unsigned NREG     = 16,
  parameter  int unsigned RA_REG   = 15,
  parameter  int unsigned SB_CNT_W = 2,
  localparam int unsigned REG_AW   = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [31:0]       if_instr,
  input  logic [XLEN-1:0]   if_pc,
  input  logic              flush,
  output logic [REG_AW-1:0] rf_a1,
  output logic [REG_AW-1:0] rf_a2,
  input  logic [XLEN-1:0]   rf_d1,
  input  logic [XLEN-1:0]   rf_d2,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [4:0]        ex_opcode,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_is_imm,
  output logic [XLEN-1:0]   ex_op1,
  output logic [XLEN-1:0]   ex_op2,
  output logic [XLEN-1:0]   ex_immx,
  output logic [XLEN-1:0]   ex_btarget
);

  localparam logic [REG_AW-1:0] RA = REG_AW'(RA_REG);

  logic [4:0]        w_op;
  logic              w_is_imm;
  logic [REG_AW-1:0] w_rd, w_rs1, w_rs2, w_dest;
  logic [15:0]       w_imm16;
  logic [XLEN-1:0]   w_immx, w_off, w_btarget;
  logic              w_use1, w_use2, w_writes;
  logic              w_busy1, w_busy2, w_dsat;
  logic              w_byp1, w_byp2;
  logic [XLEN-1:0]   w_d1, w_d2;
  logic              w_hazard, w_accept;

  logic              r_ex_valid, r_ex_is_imm, r_ex_wr;
  logic [4:0]        r_ex_opcode;
  logic [REG_AW-1:0] r_ex_rd;
  logic [XLEN-1:0]   r_ex_op1, r_ex_op2, r_ex_immx, r_ex_btarget;

  assign w_op     = if_instr[31:27];
  assign w_is_imm = if_instr[26];
  assign w_rd     = REG_AW'(if_instr[25:22]);
  assign w_rs1    = REG_AW'(if_instr[21:18]);
  assign w_rs2    = REG_AW'(if_instr[17:14]);
  assign w_imm16  = if_instr[15:0];

  assign rf_a1 = (w_op == OP_RET) ? RA : w_rs1;
  assign rf_a2 = (w_op == OP_ST) ? w_rd : w_rs2;

  assign w_use1   = uses_rs1(w_op);
  assign w_use2   = !w_is_imm || (w_op == OP_ST);
  assign w_writes = writes_rd(w_op) || (w_op == OP_CALL);
  assign w_dest   = (w_op == OP_CALL) ? RA : w_rd;

  always_comb begin
    w_immx = {{(XLEN-16){w_imm16[15]}}, w_imm16};
    case (if_instr[17:16])
      IMM_ZEXT: w_immx = {{(XLEN-16){1'b0}}, w_imm16};
      IMM_HIGH: w_immx = XLEN'({w_imm16, 16'h0000});
      default:  ;
    endcase
  end

  assign w_off     = {{(XLEN-27){if_instr[26]}}, if_instr[26:0]};
  assign w_btarget = if_pc + (w_off << 2);

`ifdef OF_WB_BYPASS_EN
  assign w_byp1 = wb_we && (wb_rd == rf_a1);
  assign w_byp2 = wb_we && (wb_rd == rf_a2);
  assign w_d1   = w_byp1 ? wb_data : rf_d1;
  assign w_d2   = w_byp2 ? wb_data : rf_d2;
`else
  logic w_unused_wb;
  assign w_unused_wb = ^wb_data;
  assign w_byp1      = 1'b0;
  assign w_byp2      = 1'b0;
  assign w_d1        = rf_d1;
  assign w_d2        = rf_d2;
`endif

  of_scoreboard #(
    .NREG     (NREG),
    .SB_CNT_W (SB_CNT_W),
    .REG_AW   (REG_AW)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_inc     (w_accept && w_writes),
    .i_inc_reg (w_dest),
    .i_dec     (wb_we),
    .i_dec_reg (wb_rd),
    .i_rb      (flush && r_ex_valid && r_ex_wr),
    .i_rb_reg  (r_ex_rd),
    .i_q1      (rf_a1),
    .i_q2      (rf_a2),
    .i_qd      (w_dest),
    .o_busy1   (w_busy1),
    .o_busy2   (w_busy2),
    .o_dsat    (w_dsat)
  );

  assign w_hazard = (w_use1 && w_busy1 && !w_byp1) ||
                    (w_use2 && w_busy2 && !w_byp2) ||
                    (w_writes && w_dsat);
  assign if_ready = (!r_ex_valid || ex_ready) && !w_hazard && !flush;
  assign w_accept = if_valid && if_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid   <= 1'b0;
      r_ex_wr      <= 1'b0;
      r_ex_opcode  <= '0;
      r_ex_rd      <= '0;
      r_ex_is_imm  <= 1'b0;
      r_ex_op1     <= '0;
      r_ex_op2     <= '0;
      r_ex_immx    <= '0;
      r_ex_btarget <= '0;
    end else if (flush) begin
      r_ex_valid <= 1'b0;
    end else if (w_accept) begin
      r_ex_valid   <= 1'b1;
      r_ex_wr      <= w_writes;
      r_ex_opcode  <= w_op;
      r_ex_rd      <= w_dest;
      r_ex_is_imm  <= w_is_imm;
      r_ex_op1     <= w_d1;
      r_ex_op2     <= w_d2;
      r_ex_immx    <= w_immx;
      r_ex_btarget <= w_btarget;
    end else if (ex_ready) begin
      r_ex_valid <= 1'b0;
    end
  end

  assign ex_valid   = r_ex_valid;
  assign ex_opcode  = r_ex_opcode;
  assign ex_rd      = r_ex_rd;
  assign ex_is_imm  = r_ex_is_imm;
  assign ex_op1     = r_ex_op1;
  assign ex_op2     = r_ex_op2;
  assign ex_immx    = r_ex_immx;
  assign ex_btarget = r_ex_btarget;

endmodule

// File: tb/tb_of_stage_pipe.sv
// tb_of_stage_pipe: directed and randomized checks of of_stage_pipe against
// a behavioural reference model (in-flight counts per register, latch contents).
module tb_of_stage_pipe;

  logic        clk, rst_n;
  logic        if_valid, if_ready, flush, wb_we, ex_valid, ex_ready, ex_is_imm;
  logic [31:0] if_instr, if_pc, rf_d1, rf_d2, wb_data;
  logic [31:0] ex_op1, ex_op2, ex_immx, ex_btarget;
  logic [3:0]  rf_a1, rf_a2, wb_rd, ex_rd;
  logic [4:0]  ex_opcode;

  logic [31:0] regfile [16];
  int          n_checks = 0;
  int          n_fail   = 0;

`ifdef OF_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // reference model state
  int          cnt [16];
  bit          m_valid, m_wr, m_imm;
  logic [4:0]  m_op;
  logic [3:0]  m_rd;
  logic [31:0] m_op1, m_op2, m_immx, m_bt;
  logic        obs_rdy;
  logic [3:0]  obs_a1;

  assign rf_d1 = regfile[rf_a1];
  assign rf_d2 = regfile[rf_a2];

  of_stage_pipe #(
    .XLEN     (32),
    .NREG     (16),
    .RA_REG   (15),
    .SB_CNT_W (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_valid   (if_valid),
    .if_ready   (if_ready),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .flush      (flush),
    .rf_a1      (rf_a1),
    .rf_a2      (rf_a2),
    .rf_d1      (rf_d1),
    .rf_d2      (rf_d2),
    .wb_we      (wb_we),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .ex_valid   (ex_valid),
    .ex_ready   (ex_ready),
    .ex_opcode  (ex_opcode),
    .ex_rd      (ex_rd),
    .ex_is_imm  (ex_is_imm),
    .ex_op1     (ex_op1),
    .ex_op2     (ex_op2),
    .ex_immx    (ex_immx),
    .ex_btarget (ex_btarget)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int op, input bit i, input int rd, input int rs1, input int rs2);
    return {5'(op), i, 4'(rd), 4'(rs1), 4'(rs2), 14'h0};
  endfunction

  function automatic logic [31:0] mk_imm(input int op, input int rd, input int md, input logic [15:0] imm);
    return {5'(op), 1'b1, 4'(rd), 4'h0, 2'(md), imm};
  endfunction

  function automatic logic [31:0] ref_immx(input logic [31:0] ins);
    logic [31:0] imm;
    imm = {16'h0, ins[15:0]};
    case (ins[17:16])
      2'b01:   return imm;
      2'b10:   return imm * 32'd65536;
      default: return (imm >= 32'h8000) ? imm + 32'hFFFF0000 : imm;
    endcase
  endfunction

  function automatic logic [31:0] ref_bt(input logic [31:0] ins, input logic [31:0] pc);
    longint off;
    off = longint'(ins[26:0]);
    if (ins[26]) off = off - (longint'(1) << 27);
    return pc + 32'(off * 4);
  endfunction

  // One clock: drive at posedge+1, check combinational outputs at negedge,
  // advance the model, then check the latch at posedge+1.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic fl, input logic we, input logic [3:0] wrd,
                       input logic [31:0] wd, input logic er);
    logic [4:0] op;
    int  a1, a2, dst;
    bit  u1, u2, wr, b1, b2, haz, rdy, acc;
    int  nc [16];
    if_valid = v; if_instr = ins; if_pc = pc; flush = fl;
    wb_we = we; wb_rd = wrd; wb_data = wd; ex_ready = er;
    #4;
    op  = ins[31:27];
    a1  = (op == 5'd20) ? 15 : int'(ins[21:18]);
    a2  = (op == 5'd15) ? int'(ins[25:22]) : int'(ins[17:14]);
    u1  = !(op inside {5'd8, 5'd9, 5'd13, 5'd16, 5'd17, 5'd18, 5'd19});
    u2  = !ins[26] || (op == 5'd15);
    wr  = (op inside {[5'd0:5'd4], [5'd6:5'd12], 5'd14}) || (op == 5'd19);
    dst = (op == 5'd19) ? 15 : int'(ins[25:22]);
    b1  = BYP && we && (int'(wrd) == a1);
    b2  = BYP && we && (int'(wrd) == a2);
    haz = (u1 && cnt[a1] != 0 && !b1) || (u2 && cnt[a2] != 0 && !b2) || (wr && cnt[dst] == 3);
    rdy = (!m_valid || er) && !haz && !fl;
    acc = v && rdy;
    check("rf_a1", rf_a1, a1);
    check("rf_a2", rf_a2, a2);
    check("if_ready", if_ready, rdy);
    obs_rdy = if_ready;
    obs_a1  = rf_a1;
    for (int r = 0; r < 16; r++) nc[r] = cnt[r];
    if (fl && m_valid && m_wr && nc[m_rd] > 0) nc[m_rd]--;
    if (acc && wr) nc[dst]++;
    if (we && nc[wrd] > 0) nc[wrd]--;
    if (fl) begin
      m_valid = 1'b0;
    end else if (acc) begin
      m_valid = 1'b1;
      m_wr    = wr;
      m_op    = op;
      m_rd    = 4'(dst);
      m_imm   = ins[26];
      m_op1   = b1 ? wd : regfile[a1];
      m_op2   = b2 ? wd : regfile[a2];
      m_immx  = ref_immx(ins);
      m_bt    = ref_bt(ins, pc);
    end else if (er) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    for (int r = 0; r < 16; r++) cnt[r] = nc[r];
    check("ex_valid", ex_valid, m_valid);
    if (m_valid) begin
      check("ex_opcode", ex_opcode, m_op);
      check("ex_rd", ex_rd, m_rd);
      check("ex_is_imm", ex_is_imm, m_imm);
      check("ex_op1", ex_op1, m_op1);
      check("ex_op2", ex_op2, m_op2);
      check("ex_immx", ex_immx, m_immx);
      check("ex_btarget", ex_btarget, m_bt);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_valid", ex_valid, 0);
    check("rst_opcode", ex_opcode, 0);
    check("rst_rd", ex_rd, 0);
    check("rst_is_imm", ex_is_imm, 0);
    check("rst_op1", ex_op1, 0);
    check("rst_op2", ex_op2, 0);
    check("rst_immx", ex_immx, 0);
    check("rst_btarget", ex_btarget, 0);
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_wr    = 1'b0;
    for (int r = 0; r < 16; r++) cnt[r] = 0;
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int r = 0; r < 16; r++)
      for (int k = 0; k < 3; k++)
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 4'(r), 32'h0, 1'b1);
  endtask

  task automatic random_run(input int n);
    logic [31:0] ins;
    for (int k = 0; k < n; k++) begin
      ins = {5'($urandom_range(0, 20)), 27'($urandom)};
      cycle($urandom_range(0, 9) < 8, ins, $urandom & 32'hFFFF_FFFC,
            $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
            4'($urandom), $urandom, $urandom_range(0, 9) < 7);
    end
  endtask

  logic [31:0] exp_imm [4];

  initial begin
    for (int r = 0; r < 16; r++) regfile[r] = $urandom;
    exp_imm[0] = 32'hFFFFFFFF; exp_imm[1] = 32'h0000FFFF;
    exp_imm[2] = 32'hFFFF0000; exp_imm[3] = 32'hFFFFFFFF;
    if_valid = 0; if_instr = '0; if_pc = '0; flush = 0;
    wb_we = 0; wb_rd = '0; wb_data = '0; ex_ready = 0;
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;

    // RAW: add r1,r2,r3 then add r4,r1,r5
    cycle(1, mk(0, 0, 1, 2, 3), 32'h40, 0, 0, 0, 0, 1);
    cycle(1, mk(0, 0, 4, 1, 5), 32'h44, 0, 0, 0, 0, 1);
    check("raw_stall0", obs_rdy, 0);
    cycle(1, mk(0, 0, 4, 1, 5), 32'h44, 0, 0, 0, 0, 1);
    check("raw_stall1", obs_rdy, 0);
    cycle(1, mk(0, 0, 4, 1, 5), 32'h44, 0, 1, 4'd1, 32'hDEAD, 1);
    check("raw_wb_cycle", obs_rdy, BYP);
    check("byp_valid", ex_valid, BYP);
    check("byp_op1", ex_op1, BYP ? 32'hDEAD : regfile[2]);
    cycle(1, mk(0, 0, 4, 1, 5), 32'h44, 0, 0, 0, 0, 1);
    check("raw_after_wb", obs_rdy, 1);
    drain();

    // immediate modifiers on mov r2,#0xFFFF (writeback same cycle keeps r2 idle)
    for (int m = 0; m < 4; m++) begin
      cycle(1, mk_imm(9, 2, m, 16'hFFFF), 32'h80, 0, 1, 4'd2, 0, 1);
      check("mov_immx", ex_immx, exp_imm[m]);
    end

    cycle(1, {5'd18, 27'h7FFFFFF}, 32'h100, 0, 0, 0, 0, 1);
    check("b_target", ex_btarget, 32'hFC);
    cycle(1, {5'd19, 27'h10}, 32'h200, 0, 0, 0, 0, 1);
    check("call_rd", ex_rd, 15);
    cycle(1, {5'd20, 27'h0}, 32'h204, 0, 0, 0, 0, 1);
    check("ret_a1", obs_a1, 15);
    check("ret_stall", obs_rdy, 0);
    drain();

    // backpressure hold, then flush with a pending IF instruction
    cycle(1, mk(0, 0, 6, 0, 0), 32'h300, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cycle(1, mk(0, 0, 7, 0, 0), 32'h304, 0, 0, 0, 0, 0);
      check("hold_rdy", obs_rdy, 0);
      check("hold_valid", ex_valid, 1);
    end
    cycle(1, mk(0, 0, 7, 0, 0), 32'h304, 1, 0, 0, 0, 0);
    check("flush_rdy", obs_rdy, 0);
    check("flush_valid", ex_valid, 0);
    cycle(1, mk(0, 0, 7, 0, 0), 32'h304, 0, 0, 0, 0, 1);
    check("refetch_valid", ex_valid, 1);
    cycle(1, mk(0, 0, 8, 6, 0), 32'h308, 0, 0, 0, 0, 1);
    check("rollback_rdy", obs_rdy, 1);
    cycle(0, 32'h0, 32'h0, 0, 1, 4'd7, 0, 1);
    cycle(1, mk(0, 0, 9, 7, 0), 32'h30C, 0, 0, 0, 0, 1);
    check("r7_single", obs_rdy, 1);
    drain();

    // WAW saturation on r3
    for (int k = 0; k < 3; k++) begin
      cycle(1, mk(0, 0, 3, 0, 0), 32'h400, 0, 0, 0, 0, 1);
      check("sat_acc", obs_rdy, 1);
    end
    cycle(1, mk(0, 0, 3, 0, 0), 32'h404, 0, 0, 0, 0, 1);
    check("sat_stall", obs_rdy, 0);
    cycle(1, mk(0, 0, 3, 0, 0), 32'h404, 0, 1, 4'd3, 0, 1);
    check("sat_wb_cycle", obs_rdy, 0);
    cycle(1, mk(0, 0, 3, 0, 0), 32'h404, 0, 0, 0, 0, 1);
    check("sat_release", obs_rdy, 1);
    drain();

    random_run(300);
    async_reset();
    random_run(300);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
